// File: rtl/seg_display_arbiter_if.sv
// Producer-side bundle for seg_display_arbiter: enable, requests and patterns in; display state out.
interface seg_display_arbiter_if;
  logic        ena;
  logic [3:0]  req;
  logic [31:0] data;
  logic [7:0]  seg;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  modport master (output ena, req, data, input seg, grant, done, busy);
  modport slave  (input ena, req, data, output seg, grant, done, busy);
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin time-multiplexer of one seven-segment bus among four sources, MAX_COUNT cycles per grant.
// Build macro SEG_PRIORITY_OVERRIDE_EN gives source 0 strict, preempting priority.
module seg_display_arbiter #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter logic [7:0]  BLANK     = 8'h00
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // A zero dwell behaves as a one-cycle dwell.
  localparam logic [23:0] LAST_CNT = (MAX_COUNT <= 24'd1) ? 24'd0 : (MAX_COUNT - 24'd1);

  state_t      state_r, state_s;
  logic [23:0] cnt_r, cnt_s;
  logic [1:0]  ptr_r, ptr_s;
  logic [1:0]  owner_r, owner_s;
  logic [7:0]  seg_r, seg_s;
  logic [3:0]  grant_r, grant_s;
  logic [3:0]  done_r, done_s;
  logic        busy_r, busy_s;
  logic [2:0]  pick_s;
  logic [1:0]  winner_s;
  logic        found_s;
  logic        keep_ptr_s;
  logic        expire_s;
  logic        hand_off_s;

  // Next requester strictly after p; p itself is considered last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Winner selection for any hand-off.
  always_comb begin
    pick_s  = rr_pick(bus.req, ptr_r);
    found_s = pick_s[2];
`ifdef SEG_PRIORITY_OVERRIDE_EN
    keep_ptr_s = bus.req[0];
    winner_s   = bus.req[0] ? 2'd0 : pick_s[1:0];
`else
    keep_ptr_s = 1'b0;
    winner_s   = pick_s[1:0];
`endif
  end

  // Next state: dwell counting, expiry, release and re-arbitration.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    expire_s   = 1'b0;
    hand_off_s = 1'b0;
    if (bus.ena) begin
      case (state_r)
        IDLE: begin
          hand_off_s = 1'b1;
        end
        SHOW: begin
          if (cnt_r == LAST_CNT) begin
            expire_s   = 1'b1;
            hand_off_s = 1'b1;
          end else if (!bus.req[owner_r]) begin
            hand_off_s = 1'b1;
`ifdef SEG_PRIORITY_OVERRIDE_EN
          end else if (bus.req[0] && (owner_r != 2'd0)) begin
            hand_off_s = 1'b1;
`endif
          end else begin
            cnt_s = cnt_r + 24'd1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
      case ({hand_off_s, found_s})
        2'b11: begin
          state_s = SHOW;
          owner_s = winner_s;
          cnt_s   = 24'd0;
          ptr_s   = keep_ptr_s ? ptr_r : winner_s;
        end
        2'b10: begin
          state_s = IDLE;
          cnt_s   = 24'd0;
        end
        default: begin
        end
      endcase
    end else begin
      expire_s = 1'b0;
    end
  end

  // Next values of the registered outputs; all but done hold while disabled.
  always_comb begin
    seg_s   = seg_r;
    grant_s = grant_r;
    busy_s  = busy_r;
    done_s  = 4'b0000;
    if (bus.ena) begin
      seg_s   = (state_r == SHOW) ? bus.data[{owner_r, 3'b000} +: 8] : BLANK;
      grant_s = (state_s == SHOW) ? (4'b0001 << owner_s) : 4'b0000;
      busy_s  = (state_s == SHOW);
      done_s  = expire_s ? (4'b0001 << owner_r) : 4'b0000;
    end else begin
      done_s = 4'b0000;
    end
  end

  // State and output registers; pointer resets to 3 so source 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 24'd0;
      ptr_r   <= 2'd3;
      owner_r <= 2'd0;
      seg_r   <= BLANK;
      grant_r <= 4'b0000;
      done_r  <= 4'b0000;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      seg_r   <= seg_s;
      grant_r <= grant_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.seg   = seg_r;
  assign bus.grant = grant_r;
  assign bus.done  = done_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (MAX_COUNT=4): reference model pushes per-edge expectations, monitor compares.
module tb_seg_display_arbiter;

  localparam int         DWELL = 4;
  localparam logic [7:0] BLANK = 8'h00;
`ifdef SEG_PRIORITY_OVERRIDE_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] grant;
    logic [3:0] done;
    logic       busy;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  resp_t q[$];

  // Reference model: who owns the display, for how long, and where round-robin resumes.
  int         m_owner;
  int         m_age;
  int         m_last;
  logic [7:0] m_seg;
  logic [3:0] m_done;

  seg_display_arbiter_if bus();

  seg_display_arbiter #(.MAX_COUNT(24'd4), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int next_req(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic int pick(input logic [3:0] r);
    if (PRIO && r[0]) return 0;
    return next_req(r, m_last);
  endfunction

  task automatic grant_to(input int w, input logic [3:0] r);
    m_owner = w;
    if (w >= 0) begin
      m_age = 0;
      if (!(PRIO && r[0])) m_last = w;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = 3;
    m_seg   = BLANK;
    m_done  = 4'b0000;
  endtask

  task automatic model_step(input logic e, input logic [3:0] r, input logic [31:0] d);
    resp_t x;
    m_done = 4'b0000;
    if (e) begin
      if (m_owner < 0) m_seg = BLANK;
      else m_seg = d[8*m_owner +: 8];
      if (m_owner < 0) grant_to(pick(r), r);
      else if (m_age == DWELL - 1) begin
        m_done[m_owner] = 1'b1;
        grant_to(pick(r), r);
      end
      else if (!r[m_owner]) grant_to(pick(r), r);
      else if (PRIO && r[0] && m_owner != 0) grant_to(pick(r), r);
      else m_age++;
    end
    x.seg   = m_seg;
    x.grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    x.done  = m_done;
    x.busy  = (m_owner >= 0);
    q.push_back(x);
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic [31:0] d);
    bus.ena  = e;
    bus.req  = r;
    bus.data = d;
    @(posedge clk);
    model_step(e, r, d);
    #2;
  endtask

  task automatic do_reset();
    resp_t a;
    rst = 1'b1;
    q.delete();
    #1;
    a = {bus.seg, bus.grant, bus.done, bus.busy};
    n_tests++;
    if (a !== {BLANK, 4'b0000, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset seg/grant/done/busy got %h/%b/%b/%b expected %h/0000/0000/0", bus.seg, bus.grant, bus.done, bus.busy, BLANK);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: one registered response per clock edge, checked mid-cycle.
  always @(negedge clk) begin
    resp_t e;
    resp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.seg, bus.grant, bus.done, bus.busy};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t seg/grant/done/busy got %h/%b/%b/%b expected %h/%b/%b/%b",
                 $time, a.seg, a.grant, a.done, a.busy, e.seg, e.grant, e.done, e.busy);
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic       dropped;
    bus.ena  = 1'b1;
    bus.req  = 4'b0000;
    bus.data = 32'h0000_0000;
    model_reset();
    #1;
    do_reset();

    repeat (10) step(1'b1, 4'b0000, $urandom);
    repeat (10) step(1'b1, 4'b0001, 32'h0000_003F);
    repeat (24) step(1'b1, 4'b1111, 32'h4433_2211);
    repeat (3) step(1'b1, 4'b0000, 32'h4433_2211);

    dropped = 1'b0;
    for (int c = 0; c < 16; c++) begin
      rq = dropped ? 4'b0100 : 4'b0110;
      step(1'b1, rq, 32'h8877_6655);
      if (m_owner == 1 && m_age == 1) dropped = 1'b1;
    end
    repeat (3) step(1'b1, 4'b0000, 32'h0);

    repeat (2) step(1'b1, 4'b1000, $urandom);
    repeat (5) step(1'b0, 4'b1000, $urandom);
    repeat (8) step(1'b1, 4'b1000, $urandom);

    repeat (3) step(1'b1, 4'b0010, $urandom);
    do_reset();

    rq = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, rq, $urandom);
      if (c == 300) do_reset();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Time-multiplexes one 8-bit seven-segment output among 4 requesting sources.
- Grants the display round-robin.
- Each grant holds for a dwell period of MAX_COUNT clock cycles.
- Sits between the datapath producers and the top-level segment output bus; it is the sole driver of the segment pins.

Parameters:
- MAX_COUNT, 24'd10_000_000, dwell cycles per grant. Legal range 1..2^24-1; 0 is treated as 1.
- BLANK, 8'h00, segment pattern driven when no grant is active.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design enable; low freezes all state.
- req  in  4  per-source display request; level-sensitive.
- data  in  32  source n pattern on data[8n+7:8n].
- seg  out  8  registered segment pattern.
- grant  out  4  one-hot current owner; all-zero when idle.
- done  out  4  one-cycle pulse on bit n when source n's dwell expires.
- busy  out  1  high while in SHOW.

Behaviour:
- Reset (asynchronous, immediate on rst=1), regardless of state:
  - Outputs: seg=BLANK, grant=0, done=0, busy=0.
  - Internal: state=IDLE, dwell counter=0, round-robin pointer=3, so source 0 wins first.
- Clock and reset:
  - Single clock clk.
  - rst is asynchronous and active-high.
  - Deassertion is sampled on the next clk edge.
- FSM states: IDLE, SHOW.
- IDLE:
  - seg=BLANK, grant=0.
  - If any req bit is set, select the next requester by searching upward from pointer+1 (mod 4).
  - Load grant, set pointer to the winner, clear the counter, go to SHOW.
  - Latency: req sampled high at edge t gives grant/busy high after edge t; seg shows data of the winner after edge t+1.
- SHOW:
  - Each cycle, seg <= data[grant] (live data, 1-cycle registered latency).
  - Counter increments by 1 per enabled cycle.
  - Expiry occurs when counter==MAX_COUNT-1 (or at the first cycle if MAX_COUNT<=1):
    - Assert done[owner] for exactly one cycle (on the edge that ends the grant).
    - Re-arbitrate in the same cycle from pointer+1.
    - The same source is re-granted only if it is the sole requester.
    - With no requesters, go to IDLE; seg=BLANK from the following edge.
  - Release occurs when req[owner] drops before expiry:
    - The grant ends on the next edge, with no done pulse.
    - Re-arbitrate as on expiry.
  - A new grant always restarts the counter at 0. There is no idle bubble between back-to-back grants.
- Simultaneous requests: resolved only by the round-robin order. Requests arriving mid-dwell never preempt, except under the Optional Feature.
- ena=0: state, counter, pointer, grant, and seg all hold; done is forced 0. Resume continues exactly where it froze.
- Reset mid-SHOW: the grant is abandoned with no done pulse.
- Counter width: 24 bits, no wrap beyond MAX_COUNT-1.

Optional Feature:
- Macro: SEG_PRIORITY_OVERRIDE_EN.
- Defined: source 0 has strict priority.
  - If req[0] rises while another source owns the display, that grant is preempted on the next edge.
  - The preempted source gets no done pulse.
  - Source 0 is granted and the counter is cleared.
  - The pointer is not advanced by the override, so round-robin order among sources 1-3 resumes where it was.
  - While source 0 holds, other requests wait.
- Undefined: pure round-robin as described above; req[0] has no special standing.

Test Plan (MAX_COUNT=4, BLANK=8'h00):
- Reset release, req=0: seg=00, grant=0000, busy=0 held for 10 cycles. Assert rst mid-SHOW: all outputs return to reset values immediately, asynchronously.
- req=0001, data[7:0]=8'h3F: grant=0001 one edge later; seg=3F the following edge; done[0] pulses after 4 cycles; grant=0001 re-issued with no blank cycle.
- req=1111 with distinct patterns 11/22/33/44: grant sequence 0001,0010,0100,1000,0001; each grant held 4 cycles; one done pulse per grant.
- req=0110, drop req[1] after 2 cycles of its grant: grant moves to 0100 next edge; done stays 0 for source 1.
- ena=0 for 5 cycles mid-dwell: counter, grant, and seg frozen, done=0; after ena=1 the dwell completes the remaining cycles exactly.
- With SEG_PRIORITY_OVERRIDE_EN, source 2 owning and req[0] rising: grant=0001 next edge, no done[2]; after source 0 releases, the next grant is 1000 if req=1100.
